// File: rtl/hr_pkg.sv
// Shared types and constants for the heart-rate sequencer: FSM states,
// sample width, default bpm width and the divider numerator width helper.
package hr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    DIVIDE,
    DONE
  } state_e;

  localparam int SAMPLE_W  = 10;
  localparam int BPM_W_DEF = 8;

  // Bits needed to hold 60*sample_hz, the beats-per-minute numerator.
  function automatic int num_w(input int sample_hz);
    return $clog2(60 * sample_hz + 1);
  endfunction

endpackage

// File: rtl/heart_rate_sequencer_bpm_divider.sv
// Serial restoring divider: one quotient bit per cycle, MSB first, with a
// fixed NUM_W-cycle latency from start to the done pulse.
module bpm_divider #(
  parameter int NUM_W = 13,
  parameter int DIV_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] numerator,
  input  logic [DIV_W-1:0] divisor,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);

  localparam int CNT_W = $clog2(NUM_W);

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [NUM_W-1:0] quo_q, quo_d;
  logic [DIV_W:0]   trial;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    div_d  = div_q;
    quo_d  = quo_q;
    trial  = {rem_q, quo_q[NUM_W-1]};
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(NUM_W - 1);
      rem_d  = '0;
      div_d  = divisor;
      quo_d  = numerator;
    end else if (busy_q) begin
      // The dividend shifts out of quo_q's MSB while quotient bits enter its LSB.
      if (trial >= {1'b0, div_q}) begin
        rem_d = DIV_W'(trial - {1'b0, div_q});
        quo_d = {quo_q[NUM_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DIV_W-1:0];
        quo_d = {quo_q[NUM_W-2:0], 1'b0};
      end
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      quo_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      div_q  <= div_d;
      quo_q  <= quo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && start) begin
      assert (divisor != '0) else $error("bpm_divider: divisor is zero at start");
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/heart_rate_sequencer.sv
// Sample-rate scheduler and beat-interval controller: captures SPI voltage
// words, strobes them out at SAMPLE_HZ, and turns peak spacing into bpm.
module heart_rate_sequencer
  import hr_pkg::*;
#(
  parameter int CLK_HZ          = 40_000_000,
  parameter int SAMPLE_HZ       = 250,
  parameter int REFRACT_SAMPLES = 75,
  parameter int TIMEOUT_SAMPLES = 750,
  parameter int BPM_W           = BPM_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_done,
  input  logic [SAMPLE_W-1:0] voltage_in,
  output logic                sample_en,
  output logic [SAMPLE_W-1:0] sample_out,
  input  logic                peak_in,
  output logic [BPM_W-1:0]    bpm,
  output logic                bpm_valid,
  output logic                no_signal,
  output logic                stale
);

  localparam int TICK_DIV = CLK_HZ / SAMPLE_HZ;
  localparam int TICK_W   = $clog2(TICK_DIV);
  localparam int NUM_W    = num_w(SAMPLE_HZ);
  localparam int CNT_W    = $clog2(TIMEOUT_SAMPLES + 1);
  localparam int QX_W     = (NUM_W > BPM_W) ? NUM_W : BPM_W;

  localparam logic [NUM_W-1:0] BEATS_NUM = NUM_W'(60 * SAMPLE_HZ);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_SAMPLES);
  localparam logic [CNT_W-1:0] REFRACT_M1 = CNT_W'(REFRACT_SAMPLES - 1);

  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [SAMPLE_W-1:0] hold_q, hold_d;
  logic [SAMPLE_W-1:0] sample_out_q, sample_out_d;
  logic                fresh_q, fresh_d;
  logic                sample_en_q, sample_en_d;
  logic                stale_q, stale_d;
  logic [CNT_W-1:0]    ivl_q, ivl_d;
  state_e              state_q, state_d;
  logic [BPM_W-1:0]    bpm_q, bpm_d;
  logic                bpm_valid_q, bpm_valid_d;
  logic                no_signal_q, no_signal_d;

  logic                tick, peak_seen, ivl_clr, div_start, div_done;
  logic [NUM_W-1:0]    quotient;
  logic [QX_W-1:0]     quo_ext;
  logic [BPM_W-1:0]    bpm_sat;

  assign tick      = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
  assign peak_seen = sample_en_q & peak_in;
  assign quo_ext   = QX_W'(quotient);
  assign bpm_sat   = (quo_ext > QX_W'({BPM_W{1'b1}})) ? '1 : quo_ext[BPM_W-1:0];

  always_comb begin
    tick_cnt_d   = tick ? '0 : tick_cnt_q + TICK_W'(1);
    hold_d       = frame_done ? voltage_in : hold_q;
    // A frame landing on the tick cycle is issued by that tick and counts as fresh.
    fresh_d      = tick ? 1'b0 : (frame_done | fresh_q);
    sample_en_d  = tick;
    sample_out_d = tick ? hold_d : sample_out_q;
    stale_d      = stale_q | (tick & ~fresh_q & ~frame_done);
    ivl_d        = ivl_q;
    if (ivl_clr) begin
      ivl_d = '0;
    end else if (sample_en_q && ivl_q != TIMEOUT_C) begin
      ivl_d = ivl_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    bpm_d       = bpm_q;
    bpm_valid_d = 1'b0;
    no_signal_d = no_signal_q;
    ivl_clr     = 1'b0;
    div_start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (peak_seen) begin
          ivl_clr = 1'b1;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        // Timeout wins, so an accepted interval never exceeds TIMEOUT_SAMPLES.
        if (ivl_q == TIMEOUT_C) begin
          bpm_d       = '0;
          bpm_valid_d = 1'b1;
          no_signal_d = 1'b1;
          state_d     = IDLE;
        end else if (peak_seen && ivl_q >= REFRACT_M1) begin
          ivl_clr   = 1'b1;
          div_start = 1'b1;
          state_d   = DIVIDE;
        end
      end
      DIVIDE: begin
        if (div_done) begin
          bpm_d       = bpm_sat;
          bpm_valid_d = 1'b1;
          no_signal_d = 1'b0;
          state_d     = DONE;
        end
      end
      DONE:    state_d = MEASURE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q   <= '0;
      hold_q       <= '0;
      sample_out_q <= '0;
      fresh_q      <= 1'b0;
      sample_en_q  <= 1'b0;
      stale_q      <= 1'b0;
      ivl_q        <= '0;
      state_q      <= IDLE;
      bpm_q        <= '0;
      bpm_valid_q  <= 1'b0;
      no_signal_q  <= 1'b1;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      hold_q       <= hold_d;
      sample_out_q <= sample_out_d;
      fresh_q      <= fresh_d;
      sample_en_q  <= sample_en_d;
      stale_q      <= stale_d;
      ivl_q        <= ivl_d;
      state_q      <= state_d;
      bpm_q        <= bpm_d;
      bpm_valid_q  <= bpm_valid_d;
      no_signal_q  <= no_signal_d;
    end
  end

  bpm_divider #(
    .NUM_W(NUM_W),
    .DIV_W(CNT_W)
  ) u_divider (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .numerator(BEATS_NUM),
    .divisor  (ivl_q + CNT_W'(1)),
    .done     (div_done),
    .quotient (quotient)
  );

  assign sample_en  = sample_en_q;
  assign sample_out = sample_out_q;
  assign bpm        = bpm_q;
  assign bpm_valid  = bpm_valid_q;
  assign no_signal  = no_signal_q;
  assign stale      = stale_q;

endmodule

// File: tb/tb_heart_rate_sequencer.sv
// Directed bench for heart_rate_sequencer; expected bpm pulses are queued when
// a peak is driven and matched (value, no_signal, latency) when bpm_valid fires.
module tb_heart_rate_sequencer;
  import hr_pkg::*;

  localparam int CLK_HZ    = 1000;
  localparam int SAMPLE_HZ = 100;
  localparam int REFRACT   = 30;
  localparam int TIMEOUT   = 300;
  localparam int LAT       = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_done = 1'b0;
  logic [9:0] voltage_in = '0;
  logic       peak_in = 1'b0;
  logic       sample_en;
  logic [9:0] sample_out;
  logic [7:0] bpm;
  logic       bpm_valid;
  logic       no_signal;
  logic       stale;

  typedef struct {
    int   bpm;
    logic nosig;
    int   due;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         se_cyc = 0;
  int         prev_se = 0;
  logic       frames_on = 1'b0;
  logic       skip_next = 1'b0;
  logic [9:0] word = 10'h155;
  logic [9:0] so;
  logic       st;

  heart_rate_sequencer #(
    .CLK_HZ         (CLK_HZ),
    .SAMPLE_HZ      (SAMPLE_HZ),
    .REFRACT_SAMPLES(REFRACT),
    .TIMEOUT_SAMPLES(TIMEOUT),
    .BPM_W          (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .frame_done(frame_done),
    .voltage_in(voltage_in),
    .sample_en (sample_en),
    .sample_out(sample_out),
    .peak_in   (peak_in),
    .bpm       (bpm),
    .bpm_valid (bpm_valid),
    .no_signal (no_signal),
    .stale     (stale)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Frame source: one frame_done every 10 clk while enabled; skip_next drops one.
  initial begin
    int cd;
    cd = 3;
    forever begin
      @(posedge clk);
      #1;
      frame_done = 1'b0;
      if (!frames_on) begin
        cd = 3;
      end else begin
        cd--;
        if (cd == 0) begin
          cd = 10;
          if (skip_next) begin
            skip_next = 1'b0;
          end else begin
            frame_done = 1'b1;
            voltage_in = word;
          end
        end
      end
    end
  end

  // bpm_valid monitor: pops the scoreboard on each pulse.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bpm_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("bpm_valid_unexpected", bpm_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          check("bpm_value", bpm, e.bpm);
          check("no_signal_at_pulse", no_signal, e.nosig);
          if (e.due >= 0) check("bpm_latency", cyc, e.due);
        end
      end
    end
  end

  // Waits for the next sample_en, drives peak_in for that cycle, optionally
  // queues the bpm the peak should produce.
  task automatic next_sample(input logic pk, input logic want, input int exp_bpm);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (sample_en !== 1'b1 && n < 40);
    if (sample_en !== 1'b1) check("sample_en_wait", sample_en, 1'b1);
    so      = sample_out;
    st      = stale;
    se_cyc  = cyc;
    peak_in = pk;
    if (want) sb.push_back('{exp_bpm, 1'b0, cyc + LAT});
    @(posedge clk);
    #1;
    peak_in = 1'b0;
  endtask

  task automatic idle_samples(input int n);
    for (int i = 0; i < n; i++) next_sample(1'b0, 1'b0, 0);
  endtask

  task automatic check_reset_outputs(input string phase);
    check({phase, "_sample_en"}, sample_en, 1'b0);
    check({phase, "_sample_out"}, sample_out, 10'h000);
    check({phase, "_bpm"}, bpm, 8'd0);
    check({phase, "_bpm_valid"}, bpm_valid, 1'b0);
    check({phase, "_no_signal"}, no_signal, 1'b1);
    check({phase, "_stale"}, stale, 1'b0);
    check({phase, "_fsm"}, dut.state_q, IDLE);
  endtask

  task automatic do_reset();
    frames_on = 1'b0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset     = 1'b0;
    frames_on = 1'b1;
  endtask

  initial begin
    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset     = 1'b0;
    frames_on = 1'b1;

    // Tick spacing and capture with a frame every sample period
    for (int i = 0; i < 5; i++) begin
      next_sample(1'b0, 1'b0, 0);
      if (i > 0) check("tick_spacing", se_cyc - prev_se, 10);
      prev_se = se_cyc;
      check("sample_out_155", so, 10'h155);
      check("stale_low", st, 1'b0);
    end

    // One missing frame: stale sets, previous word repeats, stale sticks
    word = 10'h0A3;
    next_sample(1'b0, 1'b0, 0);
    check("sample_out_0a3", so, 10'h0A3);
    check("stale_before_skip", st, 1'b0);
    skip_next = 1'b1;
    word      = 10'h2C4;
    next_sample(1'b0, 1'b0, 0);
    check("stale_on_skip", st, 1'b1);
    check("sample_out_repeat", so, 10'h0A3);
    next_sample(1'b0, 1'b0, 0);
    check("sample_out_2c4", so, 10'h2C4);
    check("stale_sticky", st, 1'b1);

    // Rate: 100-sample then 40-sample intervals
    do_reset();
    next_sample(1'b1, 1'b0, 0);
    idle_samples(99);
    check("no_signal_first_beat", no_signal, 1'b1);
    check("bpm_first_beat", bpm, 8'd0);
    next_sample(1'b1, 1'b1, 60);
    idle_samples(2);
    check("no_signal_locked", no_signal, 1'b0);
    check("bpm_hold_60", bpm, 8'd60);
    idle_samples(37);
    next_sample(1'b1, 1'b1, 150);
    idle_samples(2);
    check("bpm_hold_150", bpm, 8'd150);

    // Refractory: peak 20 samples after the accepted one is ignored
    idle_samples(17);
    next_sample(1'b1, 1'b0, 0);
    idle_samples(79);
    next_sample(1'b1, 1'b1, 60);
    idle_samples(2);
    check("bpm_after_refract", bpm, 8'd60);

    // Timeout: 300 samples without a peak, then reacquire
    sb.push_back('{0, 1'b1, -1});
    idle_samples(303);
    check("timeout_no_signal", no_signal, 1'b1);
    check("timeout_bpm", bpm, 8'd0);
    check("timeout_fsm", dut.state_q, IDLE);
    next_sample(1'b1, 1'b0, 0);
    idle_samples(99);
    next_sample(1'b1, 1'b1, 60);
    idle_samples(2);
    check("reacquire_bpm", bpm, 8'd60);
    check("reacquire_no_signal", no_signal, 1'b0);

    // Reset 5 clk into DIVIDE: operation aborted, no bpm_valid afterwards
    idle_samples(97);
    next_sample(1'b1, 1'b0, 0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("mid_divide_fsm", dut.state_q, DIVIDE);
    reset     = 1'b1;
    frames_on = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("abort");
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/heart_rate_sequencer.md
Name: heart_rate_sequencer

Overview:
Sample-rate scheduler and beat-interval controller for the heart rate monitor pipeline. It captures each voltage word delivered by the SPI slave and issues one sample strobe per sample period to the FIR filter and peak detector. It times the spacing between accepted peaks and converts each interval to beats-per-minute with a serial divider. It sits between the SPI slave and the peak detector on one side, and the seven-segment display path on the other.

Parameters:
CLK_HZ, 40000000, system clock frequency
SAMPLE_HZ, 250, sample strobe rate; CLK_HZ/SAMPLE_HZ must be an integer >= 2
REFRACT_SAMPLES, 75, minimum accepted peak spacing in samples (200 bpm ceiling)
TIMEOUT_SAMPLES, 750, samples without an accepted peak before declaring no signal
BPM_W, 8, width of the bpm output

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_done  in  1  one-cycle pulse, already synchronised to clk: SPI frame complete
voltage_in  in  10  voltage word, valid in the cycle frame_done is high
sample_en  out  1  one-cycle strobe to filter and peak detector
sample_out  out  10  sample presented with sample_en; held between strobes
peak_in  in  1  peak-detector flag; sampled only in cycles where sample_en is high
bpm  out  BPM_W  latest heart rate
bpm_valid  out  1  one-cycle pulse when bpm updates
no_signal  out  1  high while no valid beat is established
stale  out  1  sticky; a tick occurred with no new frame since the previous tick

Behaviour:
- Reset: sample_en=0, sample_out=0, bpm=0, bpm_valid=0, no_signal=1, stale=0, tick counter=0, interval counter=0, fresh=0, FSM=IDLE. Reset in any state, including DIVIDE, aborts the operation. No bpm_valid follows the reset.
- Capture:
  - frame_done=1: hold_reg <= voltage_in and fresh <= 1.
- Tick generation:
  - Tick counter counts 0..CLK_HZ/SAMPLE_HZ-1 and wraps.
  - A tick occurs on the wrap cycle.
  - In the cycle after a tick: sample_en=1 and sample_out=hold_reg.
  - If fresh=0 at the tick, stale is set and remains set until reset. The old hold_reg is still issued.
  - The tick clears fresh.
  - If frame_done and the tick coincide, the new word is captured, the tick issues it, and fresh ends at 0.
- Interval counter:
  - Increments on every sample_en cycle in every state.
  - Saturates at TIMEOUT_SAMPLES.
  - Cleared to 0 when a peak is accepted.
- FSM:
  - IDLE:
    - peak_in on a sample_en cycle: clear the counter and go to MEASURE. This is the first beat; no bpm is produced.
  - MEASURE:
    - peak_in on a sample_en cycle with counter+1 < REFRACT_SAMPLES: ignore the peak; the counter keeps incrementing.
    - peak_in with counter+1 >= REFRACT_SAMPLES: latch interval=counter+1, clear the counter, go to DIVIDE.
    - Counter reaches TIMEOUT_SAMPLES without an accepted peak: no_signal=1, bpm=0, bpm_valid pulses once, go to IDLE.
  - DIVIDE:
    - Restoring divider computes 60*SAMPLE_HZ / interval.
    - NUM_W cycles, where NUM_W = clog2(60*SAMPLE_HZ+1).
    - peak_in arriving during DIVIDE is dropped. The counter still runs.
  - DONE (one cycle):
    - bpm <= min(quotient, 2^BPM_W-1), truncating quotient.
    - bpm_valid=1, no_signal=0, go to MEASURE.
- Latency: bpm_valid is high exactly NUM_W+2 cycles after the sample_en cycle that carried the accepted peak.
- Arithmetic: all unsigned. Divisor is never 0 because interval >= REFRACT_SAMPLES >= 1; an assertion checks this.

Decomposition:
- Package hr_pkg:
  - state enum {IDLE, MEASURE, DIVIDE, DONE}
  - SAMPLE_W=10
  - BPM_W default
  - function computing NUM_W
- Sub-module bpm_divider: serial restoring divider.
  - Inputs: start, numerator, divisor.
  - Outputs: done pulse, quotient.
  - Fixed NUM_W-cycle latency.
  - Synchronous reset.

Test Plan:
Bench parameters: CLK_HZ=1000, SAMPLE_HZ=100 (tick every 10 clk), REFRACT=30, TIMEOUT=300, NUM_W=13.
1. Tick/capture: frame_done with 0x155 every 10 clk -> sample_en exactly every 10 clk, sample_out=0x155, stale stays 0.
2. Stale: skip one frame_done -> stale=1 at that tick, sample_out repeats the last word; restore frames -> stale remains 1 until reset.
3. Rate: peaks every 100 samples -> first peak gives no bpm_valid; second gives bpm=60, no_signal=0, pulse 15 clk after the peak's sample_en. Peaks every 40 samples -> bpm=150.
4. Refractory: extra peak 20 samples after an accepted peak -> ignored; next peak 100 samples after the accepted one -> bpm=60, not 75.
5. Timeout: after a valid beat, no peaks for 300 samples -> bpm=0, one bpm_valid, no_signal=1, FSM in IDLE; next two peaks 100 samples apart -> bpm=60.
6. Reset mid-DIVIDE: assert reset 5 clk after an accepted peak -> no bpm_valid, all outputs at reset values on the next cycle.
